// File: rtl/store_unit_pkg.sv
// Shared store-path constants and types for store_unit and store_lane.
// The optional misalignment check is enabled with the macro STORE_ALIGN_CHECK_EN.
package store_unit_pkg;

  // Store size encodings, shared with the MEM stage decoder.
  localparam logic [1:0] ST_SIZE_B = 2'b00;
  localparam logic [1:0] ST_SIZE_H = 2'b01;
  localparam logic [1:0] ST_SIZE_W = 2'b10;

  // Store-unit controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DONE  = 3'd2,
    ST_ERR   = 3'd3,
    ST_TOUT  = 3'd4
  } st_state_e;

  // A halfword must sit on an even address and a word on a multiple of four.
  // The reserved size code behaves like a word store.
  function automatic logic st_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic w_mis;
    w_mis = 1'b0;
    case (size)
      ST_SIZE_B: w_mis = 1'b0;
      ST_SIZE_H: w_mis = addr_lo[0];
      default:   w_mis = (addr_lo != 2'b00);
    endcase
    return w_mis;
  endfunction

endpackage

// File: rtl/store_lane.sv
// Combinational lane steering for stores: replicates the narrowed register
// value across all four byte lanes and selects the byte enables.
module store_lane
  import store_unit_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  output logic [3:0]  o_be,
  output logic [31:0] o_data
);

  // Lane data and byte enables from size and the low address bits.
  always_comb begin
    o_be   = 4'b1111;
    o_data = i_wdata;
    case (i_size)
      ST_SIZE_B: begin
        o_be   = 4'b0001 << i_addr_lo;
        o_data = {4{i_wdata[7:0]}};
      end
      ST_SIZE_H: begin
        o_be   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_data = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be   = 4'b1111;
        o_data = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store request, issues a single data-memory write
// over a valid/ack handshake and reports done, misalignment or timeout.
// Optional macro STORE_ALIGN_CHECK_EN rejects misaligned SH/SW requests.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        err,
  output logic        err_timeout
);

  st_state_e        r_state;
  st_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]  w_lane_be;
  logic [31:0] w_lane_data;
  logic        w_misalign;
  logic        w_wait_last;

  logic        w_ready_nxt;
  logic        w_we_nxt;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_tout_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_wdata_nxt;
  logic [3:0]  w_be_nxt;

  store_lane u_lane (
    .i_addr_lo (addr[1:0]),
    .i_wdata   (wdata),
    .i_size    (size),
    .o_be      (w_lane_be),
    .o_data    (w_lane_data)
  );

`ifdef STORE_ALIGN_CHECK_EN
  assign w_misalign = st_misaligned(size, addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_wait_last = (r_cnt == CNT_W'(MAX_WAIT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait counter: held at zero outside ISSUE so every ISSUE entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst || r_state != ST_ISSUE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Next-state logic; an ack on the last wait cycle still completes the store.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt = w_misalign ? ST_ERR : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          w_state_nxt = ST_DONE;
        end else if (w_wait_last) begin
          w_state_nxt = ST_TOUT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      ST_TOUT: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  // The memory-side registers double as the request latch: they load on
  // acceptance, hold through ISSUE, and data/enables clear afterwards.
  always_comb begin
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    w_we_nxt    = (w_state_nxt == ST_ISSUE);
    w_done_nxt  = (w_state_nxt == ST_DONE);
    w_err_nxt   = (w_state_nxt == ST_ERR) || (w_state_nxt == ST_TOUT);
    w_tout_nxt  = (w_state_nxt == ST_TOUT);
    w_addr_nxt  = mem_addr;
    w_wdata_nxt = '0;
    w_be_nxt    = '0;
    if (w_state_nxt == ST_ISSUE) begin
      if (r_state == ST_IDLE) begin
        w_addr_nxt  = {addr[31:2], 2'b00};
        w_wdata_nxt = w_lane_data;
        w_be_nxt    = w_lane_be;
      end else begin
        w_wdata_nxt = mem_wdata;
        w_be_nxt    = mem_be;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready   <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_ready   <= w_ready_nxt;
      mem_we      <= w_we_nxt;
      mem_addr    <= w_addr_nxt;
      mem_wdata   <= w_wdata_nxt;
      mem_be      <= w_be_nxt;
      done        <= w_done_nxt;
      err         <= w_err_nxt;
      err_timeout <= w_tout_nxt;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed cases plus randomized stores
// checked against a transaction-level reference model.
module tb_store_unit;

  localparam int unsigned MW = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        err;
  logic        err_timeout;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  store_unit #(.MAX_WAIT(MW), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .addr        (addr),
    .wdata       (wdata),
    .size        (size),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .done        (done),
    .err         (err),
    .err_timeout (err_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Control outputs packed as {req_ready, mem_we, done, err, err_timeout}.
  function automatic logic [31:0] ctl();
    return 32'({req_ready, mem_we, done, err, err_timeout});
  endfunction

  localparam logic [31:0] C_IDLE  = 32'b10000;
  localparam logic [31:0] C_ISSUE = 32'b01000;
  localparam logic [31:0] C_DONE  = 32'b00100;
  localparam logic [31:0] C_ERR   = 32'b00010;
  localparam logic [31:0] C_TOUT  = 32'b00011;

  // Reference model: lane results from plain arithmetic on size and address.
  function automatic logic [3:0] m_be(input int unsigned sz, input logic [31:0] a);
    int unsigned lo;
    lo = a % 4;
    if (sz == 0) return 4'(1 << lo);
    if (sz == 1) return 4'(3 << (2 * (lo / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_data(input int unsigned sz, input logic [31:0] w);
    if (sz == 0) return (w % 256) * 32'h0101_0101;
    if (sz == 1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic bit m_misaligned(input int unsigned sz, input logic [31:0] a);
`ifdef STORE_ALIGN_CHECK_EN
    if (sz == 1) return (a % 2) != 0;
    if (sz >= 2) return (a % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // One full store from IDLE. ack_at = ISSUE cycle index carrying mem_ack; <0 or >=MW never acks.
  task automatic do_store(input logic [31:0] a, input logic [31:0] w, input int unsigned sz, input int ack_at);
    logic [3:0]  e_be;
    logic [31:0] e_data;
    bit          acked;
    e_be   = m_be(sz, a);
    e_data = m_data(sz, w);
    acked  = 1'b0;
    // Idle cycle with a possible stray ack, which must have no effect.
    check_eq("idle_ctl", ctl(), C_IDLE);
    req_valid = 1'b0;
    mem_ack   = 1'($urandom % 2);
    @(negedge clk);
    check_eq("idle_ctl2", ctl(), C_IDLE);
    check_eq("idle_be", 32'(mem_be), 32'h0);
    check_eq("idle_wdata", mem_wdata, 32'h0);
    req_valid = 1'b1;
    addr      = a;
    wdata     = w;
    size      = 2'(sz);
    mem_ack   = 1'b0;
    @(negedge clk);
    if (m_misaligned(sz, a)) begin
      check_eq("mis_ctl", ctl(), C_ERR);
      req_valid = 1'b0;
      @(negedge clk);
      return;
    end
    for (int k = 0; k < int'(MW); k++) begin
      check_eq("issue_ctl", ctl(), C_ISSUE);
      check_eq("issue_addr", mem_addr, (a / 4) * 4);
      check_eq("issue_be", 32'(mem_be), 32'(e_be));
      check_eq("issue_wdata", mem_wdata, e_data);
      // Junk request inputs while busy must be ignored.
      req_valid = 1'($urandom % 2);
      addr      = $urandom;
      wdata     = $urandom;
      size      = 2'($urandom % 4);
      mem_ack   = (k == ack_at);
      @(negedge clk);
      if (k == ack_at) begin
        acked = 1'b1;
        break;
      end
    end
    check_eq(acked ? "done_ctl" : "tout_ctl", ctl(), acked ? C_DONE : C_TOUT);
    check_eq("term_be", 32'(mem_be), 32'h0);
    check_eq("term_wdata", mem_wdata, 32'h0);
    req_valid = 1'b0;
    mem_ack   = 1'($urandom % 2);
    @(negedge clk);
    mem_ack   = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    addr      = '0;
    wdata     = '0;
    size      = '0;
    mem_ack   = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ctl", ctl(), C_IDLE);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_be", 32'(mem_be), 32'h0);
    check_eq("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_store(32'h0000_1003, 32'h1234_5678, 0, 0);
    do_store(32'h0000_2002, 32'hAAAA_BEEF, 1, 3);
    do_store(32'h0000_3000, 32'hCAFE_F00D, 2, -1);
    do_store(32'h0000_3004, 32'h0BAD_CAFE, 2, int'(MW) - 1);
    do_store(32'h0000_4001, 32'hDEAD_BEEF, 2, 0);
    do_store(32'h0000_5003, 32'h0102_0304, 1, 1);
    do_store(32'h0000_6002, 32'h5566_7788, 3, 2);

    // Reset in the second ISSUE cycle aborts the store silently.
    check_eq("pre_rst_ctl", ctl(), C_IDLE);
    req_valid = 1'b1;
    addr      = 32'h0000_7000;
    wdata     = 32'h1111_2222;
    size      = 2'(2);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("ab_issue1", ctl(), C_ISSUE);
    @(negedge clk);
    check_eq("ab_issue2", ctl(), C_ISSUE);
    rst = 1'b1;
    @(negedge clk);
    check_eq("ab_rst_ctl", ctl(), C_IDLE);
    check_eq("ab_rst_be", 32'(mem_be), 32'h0);
    check_eq("ab_rst_addr", mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ab_after_ctl", ctl(), C_IDLE);

    // Randomized stores.
    for (int i = 0; i < 60; i++) begin
      int unsigned sz;
      int          ack;
      sz  = $urandom % 4;
      ack = int'($urandom_range(0, MW + 2));
      do_store($urandom, $urandom, sz, ack);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Store-path counterpart of the load-side immediate/data extender: narrows a 32-bit register value to byte/half/word, replicates it across memory byte lanes and generates byte enables.
- Sits between the MEM stage and the data-memory write port.
- Issues one write per request over a valid/ack handshake, with a wait-state timeout.

Parameters:
- MAX_WAIT, 15: cycles in ISSUE without mem_ack before a timeout is raised; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit idle and able to accept a request.
- addr  in  32  byte address of the store.
- wdata  in  32  register data; only the low byte/half is used for SB/SH.
- size  in  2  store size, using the shared ST_SIZE_* constants.
- mem_we  out  1  write strobe to data memory.
- mem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables, little-endian (bit0 = bits 7:0).
- mem_ack  in  1  memory accepted the write.
- done  out  1  one-cycle pulse: store completed.
- err  out  1  one-cycle pulse: store misaligned or timed out.
- err_timeout  out  1  qualifies err: 1 = timeout, 0 = misalign; valid only while err=1.

Behaviour:
- Reset values: req_ready=1; mem_we, mem_be, mem_addr, mem_wdata, done, err, err_timeout all 0; state=IDLE; counter=0.
- States:
  - IDLE: req_ready=1. When req_valid=1, latch addr/wdata/size and compute lanes. If misaligned (optional feature), go to ERR; otherwise go to ISSUE.
  - ISSUE: mem_we=1 and mem_addr/mem_wdata/mem_be held stable. If mem_ack=1, go to DONE. Otherwise increment the counter; when counter==MAX_WAIT-1 with no ack, go to TOUT.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: err=1, err_timeout=0, mem_we=0, for one cycle, then IDLE.
  - TOUT: err=1, err_timeout=1, mem_we=0, for one cycle, then IDLE.
- Lane rules:
  - SB: mem_wdata = {4{wdata[7:0]}}; mem_be = 4'b0001 << addr[1:0].
  - SH: mem_wdata = {2{wdata[15:0]}}; mem_be = addr[1] ? 4'b1100 : 4'b0011.
  - SW and reserved 2'b11: mem_wdata = wdata; mem_be = 4'b1111.
- Latency:
  - Request accepted at edge N; mem_we=1 from N+1.
  - mem_ack sampled high at edge M gives done=1 in cycle M+1.
  - Minimum request-to-done is 2 cycles (ack in the first ISSUE cycle).
- Registers: all outputs are registered. mem_be and mem_wdata return to 0 outside ISSUE.
- Handshake rules:
  - mem_ack outside ISSUE is ignored.
  - req_valid outside IDLE is ignored; there is no queueing.
  - The requester holds req_valid until it sees req_ready=1.
  - Back-to-back requests: a new request is accepted only after the DONE/ERR/TOUT cycle returns to IDLE.
- Counter: cleared on entry to ISSUE. mem_ack in the same cycle the counter hits MAX_WAIT-1 wins: the store completes and no timeout is raised.
- Reset mid-operation: at the next edge return to IDLE with all reset values. No done or err is produced for the aborted store.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- Defined:
  - SH with addr[0]=1 is misaligned.
  - SW with addr[1:0]!=0 is misaligned.
  - A misaligned request goes IDLE→ERR, and mem_we is never asserted.
- Undefined:
  - No check is made; the low address bits only select lanes.
  - SH uses addr[1]; SW ignores addr[1:0].
  - The ERR state is unreachable.

Decomposition:
- Shared constants file (alongside the EXT_OP_* macros): ST_SIZE_B=2'b00, ST_SIZE_H=2'b01, ST_SIZE_W=2'b10, plus the state encodings.
- One natural combinational sub-module, store_lane: inputs addr[1:0], wdata, size; outputs be and lane data. It is instantiated by store_unit and unit-tested on its own.

Test Plan:
- SB, addr=0x1003, wdata=0x12345678, ack on the first ISSUE cycle → mem_addr=0x1000, mem_wdata=0x78787878, mem_be=4'b1000, done pulses two cycles after acceptance.
- SH, addr=0x2002, wdata=0xAAAABEEF, ack after 3 wait cycles → mem_wdata=0xBEEFBEEF, mem_be=4'b1100, mem_we high for exactly 4 cycles, one done pulse.
- SW, addr=0x3000, never ack, MAX_WAIT=15 → mem_we high for 15 cycles, then err=1 and err_timeout=1 for one cycle, then req_ready=1.
- With STORE_ALIGN_CHECK_EN, SW at addr=0x4001 → err=1, err_timeout=0, mem_we never asserted. Without it, the same request gives mem_be=4'b1111, mem_addr=0x4000, done.
- Assert rst in the second ISSUE cycle → next cycle mem_we=0, req_ready=1, no done/err. A stray mem_ack while IDLE → no output change.
